// File: rtl/cache_line_ctrl.sv
// Write-back cache line controller: serves hits, writes back dirty victims and refills lines beat by beat.
// Optional perf counters (hit/miss/writeback) are built only when CACHE_LINE_CTRL_PERF_EN is defined.
module cache_line_ctrl #(
  parameter int MEM_LATENCY = 4,
  parameter int LINE_WORDS  = 1,
  parameter int WIDX        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic            hit,
  input  logic            dirty,
  output logic            stall,
  output logic            reg_write_enable,
  output logic            cache_we,
  output logic            cache_in_select,
  output logic            dirty_set,
  output logic            dirty_clr,
  output logic            mem_we,
  output logic            mem_re,
  output logic            mem_in_select,
  output logic [WIDX-1:0] word_idx
`ifdef CACHE_LINE_CTRL_PERF_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count,
  output logic [31:0]     wb_count
`endif
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0]   CYC_LAST  = CW'(MEM_LATENCY - 1);
  localparam logic [WIDX-1:0] BEAT_LAST = WIDX'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [WIDX-1:0] beat_q, beat_d;
  logic            cyc_last, beat_last;

  assign cyc_last  = (cyc_q == CYC_LAST);
  assign beat_last = (beat_q == BEAT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cyc_d            = cyc_q;
    beat_d           = beat_q;
    stall            = 1'b0;
    reg_write_enable = 1'b0;
    cache_we         = 1'b0;
    cache_in_select  = 1'b0;
    dirty_set        = 1'b0;
    dirty_clr        = 1'b0;
    mem_we           = 1'b0;
    mem_re           = 1'b0;
    mem_in_select    = 1'b0;
    word_idx         = beat_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            if (req_we) begin
              cache_we        = 1'b1;
              cache_in_select = 1'b1;
              dirty_set       = 1'b1;
            end else begin
              reg_write_enable = 1'b1;
            end
          end else begin
            stall   = 1'b1;
            state_d = dirty ? WB : REFILL;
            cyc_d   = '0;
            beat_d  = '0;
          end
        end
      end

      WB: begin
        stall         = 1'b1;
        mem_in_select = 1'b1;
        mem_we        = (cyc_q == '0);
        if (cyc_last) begin
          cyc_d = '0;
          if (beat_last) begin
            state_d = REFILL;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      REFILL: begin
        stall  = 1'b1;
        mem_re = (cyc_q == '0);
        if (cyc_last) begin
          // Memory data is valid on the last cycle of the beat.
          cache_we = 1'b1;
          cyc_d    = '0;
          if (beat_last) begin
            dirty_clr = 1'b1;
            state_d   = IDLE;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        beat_d  = '0;
      end
    endcase
  end

`ifdef CACHE_LINE_CTRL_PERF_EN
  // Marks the IDLE cycle right after a refill so the replayed hit is not counted.
  logic replay_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      replay_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      replay_q <= (state_q == REFILL) && (state_d == IDLE);
      if ((state_q == IDLE) && req_valid && hit && !replay_q && (hit_count != '1))
        hit_count <= hit_count + 1'b1;
      if ((state_q == IDLE) && req_valid && !hit && (miss_count != '1))
        miss_count <= miss_count + 1'b1;
      if ((state_q != WB) && (state_d == WB) && (wb_count != '1))
        wb_count <= wb_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed self-checking bench for cache_line_ctrl across three parameter sets.
module tb_cache_line_ctrl;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic hit = 1'b0;
  logic dirty = 1'b0;

  // Output vector order: stall, reg_write_enable, cache_we, cache_in_select,
  // dirty_set, dirty_clr, mem_we, mem_re, mem_in_select
  wire [8:0] o_a, o_b, o_c;
  wire [0:0] wi_a, wi_c;
  wire [1:0] wi_b;
`ifdef CACHE_LINE_CTRL_PERF_EN
  wire [31:0] hc_a, mc_a, wc_a, hc_b, mc_b, wc_b, hc_c, mc_c, wc_c;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_line_ctrl u_a (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_we(req_we), .hit(hit), .dirty(dirty),
    .stall(o_a[8]), .reg_write_enable(o_a[7]), .cache_we(o_a[6]), .cache_in_select(o_a[5]),
    .dirty_set(o_a[4]), .dirty_clr(o_a[3]), .mem_we(o_a[2]), .mem_re(o_a[1]),
    .mem_in_select(o_a[0]), .word_idx(wi_a)
`ifdef CACHE_LINE_CTRL_PERF_EN
    , .hit_count(hc_a), .miss_count(mc_a), .wb_count(wc_a)
`endif
  );

  cache_line_ctrl #(.MEM_LATENCY(2), .LINE_WORDS(4)) u_b (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_we(req_we), .hit(hit), .dirty(dirty),
    .stall(o_b[8]), .reg_write_enable(o_b[7]), .cache_we(o_b[6]), .cache_in_select(o_b[5]),
    .dirty_set(o_b[4]), .dirty_clr(o_b[3]), .mem_we(o_b[2]), .mem_re(o_b[1]),
    .mem_in_select(o_b[0]), .word_idx(wi_b)
`ifdef CACHE_LINE_CTRL_PERF_EN
    , .hit_count(hc_b), .miss_count(mc_b), .wb_count(wc_b)
`endif
  );

  cache_line_ctrl #(.MEM_LATENCY(1), .LINE_WORDS(1)) u_c (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_we(req_we), .hit(hit), .dirty(dirty),
    .stall(o_c[8]), .reg_write_enable(o_c[7]), .cache_we(o_c[6]), .cache_in_select(o_c[5]),
    .dirty_set(o_c[4]), .dirty_clr(o_c[3]), .mem_we(o_c[2]), .mem_re(o_c[1]),
    .mem_in_select(o_c[0]), .word_idx(wi_c)
`ifdef CACHE_LINE_CTRL_PERF_EN
    , .hit_count(hc_c), .miss_count(mc_c), .wb_count(wc_c)
`endif
  );

  task automatic drive(input logic v, input logic we, input logic h, input logic d);
    req_valid = v;
    req_we    = we;
    hit       = h;
    dirty     = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_a !== 9'b0 || o_b !== 9'b0 || o_c !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: a=%b b=%b c=%b expected all 0", o_a, o_b, o_c);
    end
    checks++;
    if (wi_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_word_idx: got %0d expected 0", wi_b);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (o_a !== 9'b0) begin
      errors++;
      $display("FAIL idle_no_valid: got %b expected 0", o_a);
    end
`ifdef CACHE_LINE_CTRL_PERF_EN
    checks++;
    if (hc_a !== 32'd0 || mc_a !== 32'd0 || wc_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: hit=%0d miss=%0d wb=%0d expected 0", hc_a, mc_a, wc_a);
    end
`endif
    step();
  endtask

  task automatic test_hits();
    logic [8:0] exp_tbl [4];
    exp_tbl = '{9'b010000000, 9'b001110000, 9'b010000000, 9'b000000000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, c == 1, 1'b1, 1'b1);
      checks++;
      if (o_a !== exp_tbl[c]) begin
        errors++;
        $display("FAIL hit_seq cyc %0d: got %b expected %b", c, o_a, exp_tbl[c]);
      end
      step();
    end
  endtask

  task automatic test_clean_miss();
    logic [8:0] exp_tbl [7];
    exp_tbl = '{9'b100000000, 9'b100000010, 9'b100000000, 9'b100000000,
                9'b101001000, 9'b010000000, 9'b000000000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(c < 6, 1'b0, c == 5, 1'b0);
      checks++;
      if (o_a !== exp_tbl[c]) begin
        errors++;
        $display("FAIL clean_miss cyc %0d: got %b expected %b", c, o_a, exp_tbl[c]);
      end
      step();
    end
  endtask

  task automatic test_dirty_store_miss();
    logic [8:0] exp;
    logic [1:0] exp_wi;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      drive(1'b1, 1'b1, c == 17, 1'b1);
      exp_wi = 2'd0;
      if (c == 0) exp = 9'b100000000;
      else if (c <= 8) begin
        exp    = (c % 2 == 1) ? 9'b100000101 : 9'b100000001;
        exp_wi = 2'((c - 1) / 2);
      end else if (c <= 16) begin
        exp    = (c % 2 == 1) ? 9'b100000010 : ((c == 16) ? 9'b101001000 : 9'b101000000);
        exp_wi = 2'((c - 9) / 2);
      end else exp = 9'b001110000;
      checks++;
      if (o_b !== exp || wi_b !== exp_wi) begin
        errors++;
        $display("FAIL dirty_store_miss cyc %0d: got %b idx %0d expected %b idx %0d",
                 c, o_b, wi_b, exp, exp_wi);
      end
      step();
    end
  endtask

  task automatic test_latency_one();
    logic [8:0] exp_tbl [3];
    exp_tbl = '{9'b100000000, 9'b101001010, 9'b010000000};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, c == 2, 1'b0);
      checks++;
      if (o_c !== exp_tbl[c]) begin
        errors++;
        $display("FAIL latency_one cyc %0d: got %b expected %b", c, o_c, exp_tbl[c]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_refill();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_a !== 9'b100000010) begin
      errors++;
      $display("FAIL reset_mid_refill_start: got %b expected 100000010", o_a);
    end
    step();
    rst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (o_a !== 9'b0) begin
        errors++;
        $display("FAIL reset_mid_refill_after cyc %0d: got %b expected 0", c, o_a);
      end
      step();
    end
  endtask

  task automatic test_drop_valid();
    logic [8:0] exp_tbl [7];
    exp_tbl = '{9'b100000000, 9'b100000010, 9'b100000000, 9'b100000000,
                9'b101001000, 9'b000000000, 9'b000000000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 1'b0, c != 0, c != 0);
      checks++;
      if (o_a !== exp_tbl[c]) begin
        errors++;
        $display("FAIL drop_valid cyc %0d: got %b expected %b", c, o_a, exp_tbl[c]);
      end
      step();
    end
  endtask

  task automatic test_perf();
`ifdef CACHE_LINE_CTRL_PERF_EN
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, c == 9, 1'b1);
      if (c == 4) begin
        checks++;
        if (o_a !== 9'b100000001) begin
          errors++;
          $display("FAIL perf_wb_last: got %b expected 100000001", o_a);
        end
      end
      if (c == 9) begin
        checks++;
        if (o_a !== 9'b010000000) begin
          errors++;
          $display("FAIL perf_replay: got %b expected 010000000", o_a);
        end
      end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hc_a !== 32'd3 || mc_a !== 32'd1 || wc_a !== 32'd1) begin
      errors++;
      $display("FAIL perf_counts: hit=%0d miss=%0d wb=%0d expected 3 1 1", hc_a, mc_a, wc_a);
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_hits();
    test_clean_miss();
    test_dirty_store_miss();
    test_latency_one();
    test_reset_mid_refill();
    test_drop_valid();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_line_ctrl.md
Name: cache_line_ctrl

Overview:
Parametrised write-back cache controller FSM between the pipeline's load/store stage and main memory. It handles hit service, dirty-line writeback and line refill. Memory latency and words per line are configurable, and each line moves beat by beat. The controller stalls the pipeline for the whole miss, then replays the access as a hit.

Parameters:
MEM_LATENCY, 4, cycles per memory beat (>=1); memory data valid on the last cycle of a beat
LINE_WORDS, 1, 32-bit words per cache line (power of 2, >=1)
WIDX, $clog2(LINE_WORDS) with minimum 1, width of word_idx

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  synchronous active-low reset, sampled on rising clk edge
req_valid  in  1  load/store access present this cycle
req_we  in  1  1=store (SW), 0=load (LW)
hit  in  1  tag match for the requested line
dirty  in  1  victim line dirty bit
stall  out  1  freeze pipeline
reg_write_enable  out  1  load data to register file
cache_we  out  1  cache data-array write strobe
cache_in_select  out  1  1=store data into cache, 0=memory data into cache
dirty_set  out  1  set dirty bit, asserted with store-hit write
dirty_clr  out  1  clear dirty bit, asserted with last refill write
mem_we  out  1  memory write strobe, first cycle of a writeback beat
mem_re  out  1  memory read strobe, first cycle of a refill beat
mem_in_select  out  1  1=memory address from victim tag, 0=from request
word_idx  out  WIDX  current beat word index

Behaviour:
- Reset (rst_b=0 at a clk edge): state=IDLE, beat and cycle counters=0. All outputs are 0 while req_valid=0 or in IDLE.
- Reset mid-miss aborts the transfer and returns to IDLE. No further memory strobes are issued.
- States: IDLE, WB, REFILL. The cycle counter runs 0..MEM_LATENCY-1. The beat counter runs 0..LINE_WORDS-1 and drives word_idx.
- IDLE, req_valid&hit, load: reg_write_enable=1 for one cycle, stall=0.
- IDLE, req_valid&hit, store: cache_we=1, cache_in_select=1, dirty_set=1 for one cycle, stall=0.
- IDLE, req_valid&!hit: stall=1. Next state is WB if dirty=1, else REFILL. Counters are cleared.
- WB: mem_in_select=1 and stall=1 throughout. mem_we=1 only when cycle counter=0.
  - At cycle=MEM_LATENCY-1 the beat advances.
  - After the last beat the FSM goes to REFILL with counters cleared.
- REFILL: mem_in_select=0 and stall=1. mem_re=1 when cycle=0.
  - At cycle=MEM_LATENCY-1: cache_we=1, cache_in_select=0.
  - On the last beat dirty_clr=1 and next state is IDLE.
- Replay: back in IDLE with hit now 1, the access completes as a hit. stall drops in that cycle.
- Latency, defaults (MEM_LATENCY=4, LINE_WORDS=1):
  - Clean miss: miss at cycle 0, REFILL cycles 1-4 (cache_we at 4), hit service at cycle 5.
  - Dirty miss: WB cycles 1-4, REFILL cycles 5-8, service at cycle 9.
  - General: miss penalty = (dirty?2:1)*LINE_WORDS*MEM_LATENCY cycles.
- MEM_LATENCY=1: mem_re and cache_we assert in the same REFILL cycle.
- req_valid dropped mid-miss: the line transfer still completes. No reg_write_enable or store write follows.
- hit and dirty are ignored outside IDLE. req_we is sampled only in IDLE.
- Outputs are decoded combinationally from state, counters and IDLE inputs. No output is asserted in more than one state for the same purpose.

Optional Feature:
CACHE_LINE_CTRL_PERF_EN.
- Defined: adds outputs hit_count, miss_count, wb_count (each 32 bit, saturating at 2^32-1), all cleared by reset.
  - hit_count increments on first-pass IDLE hits; replays are not counted.
  - miss_count increments on IDLE misses.
  - wb_count increments on entry to WB.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load hit, req_valid=1 req_we=0 hit=1 -> reg_write_enable=1 same cycle, stall=0, no mem strobes.
- Store hit -> cache_we=1, cache_in_select=1, dirty_set=1 for one cycle, stall=0.
- Clean load miss, defaults -> stall high cycles 0-4, mem_re at cycle 1, cache_we+dirty_clr at cycle 4, reg_write_enable at cycle 5 once hit=1.
- Dirty store miss, LINE_WORDS=4, MEM_LATENCY=2 -> mem_we at WB cycles 1,3,5,7 (word_idx 0-3), mem_re at cycles 9,11,13,15, store write at cycle 17.
- rst_b=0 during REFILL beat -> next edge state IDLE, all outputs 0, no further mem_re.
- With CACHE_LINE_CTRL_PERF_EN, 3 hits + 1 dirty miss -> hit_count=3, miss_count=1, wb_count=1.
